// File: rtl/id_exe_stage_reg.sv
// ID-to-EXE pipeline register with RAW hazard detection, bubble insertion and a
// saturating stall counter.
module id_exe_stage_reg #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CMD_W      = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  forward_en,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [DATA_W-1:0]     id_val1,
    input  logic [DATA_W-1:0]     id_val2,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic [CMD_W-1:0]      id_cmd,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    output logic                  stall_id,
    output logic                  exe_valid,
    output logic [REG_ADDR_W-1:0] exe_src1,
    output logic [REG_ADDR_W-1:0] exe_src2,
    output logic [REG_ADDR_W-1:0] exe_dest,
    output logic [DATA_W-1:0]     exe_val1,
    output logic [DATA_W-1:0]     exe_val2,
    output logic                  exe_wb_en,
    output logic                  exe_mem_r_en,
    output logic                  exe_mem_w_en,
    output logic [CMD_W-1:0]      exe_cmd,
    output logic [CNT_W-1:0]      stall_cycles
);

    logic hit_exe;
    logic hit_mem;
    logic hazard;

    // Source-vs-destination match against the instructions in EXE and MEM.
    always_comb begin
        hit_exe = exe_valid & exe_wb_en &
                  ((id_src1_used & (id_src1 == exe_dest)) |
                   (id_src2_used & (id_src2 == exe_dest)));
        hit_mem = mem_wb_en &
                  ((id_src1_used & (id_src1 == mem_dest)) |
                   (id_src2_used & (id_src2 == mem_dest)));
        hazard  = forward_en ? (hit_exe & exe_mem_r_en) : (hit_exe | hit_mem);
    end

    // Gated by rst_n so IF/ID is never held while the pipe is in reset.
    assign stall_id = rst_n & id_valid & hazard & ~flush;

    // Freeze outranks flush so the instruction already in EXE survives a hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid    <= 1'b0;
            exe_src1     <= '0;
            exe_src2     <= '0;
            exe_dest     <= '0;
            exe_val1     <= '0;
            exe_val2     <= '0;
            exe_wb_en    <= 1'b0;
            exe_mem_r_en <= 1'b0;
            exe_mem_w_en <= 1'b0;
            exe_cmd      <= '0;
            stall_cycles <= '0;
        end else if (!freeze) begin
            if (flush || stall_id) begin
                exe_valid    <= 1'b0;
                exe_src1     <= '0;
                exe_src2     <= '0;
                exe_dest     <= '0;
                exe_val1     <= '0;
                exe_val2     <= '0;
                exe_wb_en    <= 1'b0;
                exe_mem_r_en <= 1'b0;
                exe_mem_w_en <= 1'b0;
                exe_cmd      <= '0;
                if (stall_id && (stall_cycles != '1)) begin
                    stall_cycles <= stall_cycles + CNT_W'(1);
                end
            end else begin
                exe_valid    <= id_valid;
                exe_src1     <= id_src1;
                exe_src2     <= id_src2;
                exe_dest     <= id_dest;
                exe_val1     <= id_val1;
                exe_val2     <= id_val2;
                exe_wb_en    <= id_wb_en;
                exe_mem_r_en <= id_mem_r_en;
                exe_mem_w_en <= id_mem_w_en;
                exe_cmd      <= id_cmd;
            end
        end
    end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: directed hazard scenarios plus random
// traffic against an instruction-level pipeline model.
module tb_id_exe_stage_reg;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned NW = 4;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] src1;
        logic [AW-1:0] src2;
        logic [AW-1:0] dest;
        logic [DW-1:0] val1;
        logic [DW-1:0] val2;
        logic          wb_en;
        logic          mem_r_en;
        logic          mem_w_en;
        logic [CW-1:0] cmd;
    } instr_t;

    typedef struct {
        logic          stall;
        instr_t        exe;
        logic [NW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          forward_en = 1'b0;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_src1 = '0;
    logic [AW-1:0] id_src2 = '0;
    logic          id_src1_used = 1'b0;
    logic          id_src2_used = 1'b0;
    logic [AW-1:0] id_dest = '0;
    logic [DW-1:0] id_val1 = '0;
    logic [DW-1:0] id_val2 = '0;
    logic          id_wb_en = 1'b0;
    logic          id_mem_r_en = 1'b0;
    logic          id_mem_w_en = 1'b0;
    logic [CW-1:0] id_cmd = '0;
    logic [AW-1:0] mem_dest = '0;
    logic          mem_wb_en = 1'b0;
    logic          stall_id;
    logic          exe_valid;
    logic [AW-1:0] exe_src1;
    logic [AW-1:0] exe_src2;
    logic [AW-1:0] exe_dest;
    logic [DW-1:0] exe_val1;
    logic [DW-1:0] exe_val2;
    logic          exe_wb_en;
    logic          exe_mem_r_en;
    logic          exe_mem_w_en;
    logic [CW-1:0] exe_cmd;
    logic [NW-1:0] stall_cycles;

    id_exe_stage_reg #(
        .REG_ADDR_W(AW), .DATA_W(DW), .CMD_W(CW), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .forward_en(forward_en), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .id_dest(id_dest),
        .id_val1(id_val1), .id_val2(id_val2), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_cmd(id_cmd),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .stall_id(stall_id),
        .exe_valid(exe_valid), .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_val1(exe_val1), .exe_val2(exe_val2), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en), .exe_cmd(exe_cmd),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    exp_t   sb[$];

    // Model of the pipeline: what sits in EXE, what sits in MEM, bubbles so far.
    instr_t        m_exe = '0;
    logic [NW-1:0] m_cnt = '0;
    logic [AW-1:0] m_mem_dest = '0;
    logic          m_mem_wb = 1'b0;
    bit            last_stall = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit reads(instr_t i, bit u1, bit u2, logic [AW-1:0] r);
        return (u1 && i.src1 == r) || (u2 && i.src2 == r);
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid    = ($urandom_range(0, 3) != 0);
        i.src1     = AW'($urandom_range(0, 3));
        i.src2     = AW'($urandom_range(0, 3));
        i.dest     = AW'($urandom_range(0, 3));
        i.val1     = $urandom;
        i.val2     = $urandom;
        i.wb_en    = 1'($urandom_range(0, 1));
        i.mem_r_en = 1'($urandom_range(0, 1));
        i.mem_w_en = 1'($urandom_range(0, 1));
        i.cmd      = CW'($urandom_range(0, 15));
        return i;
    endfunction

    function automatic instr_t mk(bit v, int s1, int s2, int d, bit wb, bit ld);
        instr_t i;
        i.valid    = v;
        i.src1     = AW'(s1);
        i.src2     = AW'(s2);
        i.dest     = AW'(d);
        i.val1     = $urandom;
        i.val2     = $urandom;
        i.wb_en    = wb;
        i.mem_r_en = ld;
        i.mem_w_en = 1'b0;
        i.cmd      = CW'($urandom_range(1, 15));
        return i;
    endfunction

    // One clock of stimulus: drive ID/control inputs, predict, push expectation.
    task automatic step(input instr_t id, input bit u1, input bit u2, input bit fwd,
                        input bit frz, input bit fl, input bit rst);
        bit   in_exe, in_mem, haz, stl;
        exp_t e;
        @(negedge clk);
        rst_n = rst; forward_en = fwd; freeze = frz; flush = fl;
        id_valid = id.valid; id_src1 = id.src1; id_src2 = id.src2;
        id_src1_used = u1; id_src2_used = u2; id_dest = id.dest;
        id_val1 = id.val1; id_val2 = id.val2; id_wb_en = id.wb_en;
        id_mem_r_en = id.mem_r_en; id_mem_w_en = id.mem_w_en; id_cmd = id.cmd;
        mem_dest = m_mem_dest; mem_wb_en = m_mem_wb;
        #1;
        in_exe = m_exe.valid && m_exe.wb_en && reads(id, u1, u2, m_exe.dest);
        in_mem = m_mem_wb && reads(id, u1, u2, m_mem_dest);
        haz    = fwd ? (in_exe && m_exe.mem_r_en) : (in_exe || in_mem);
        stl    = rst && id.valid && haz && !fl;
        if (!rst) begin
            m_exe = '0; m_cnt = '0; m_mem_dest = '0; m_mem_wb = 1'b0;
        end else if (!frz) begin
            m_mem_dest = m_exe.dest;
            m_mem_wb   = m_exe.valid && m_exe.wb_en;
            if (fl || stl) begin
                m_exe = '0;
                if (stl && int'(m_cnt) < (1 << NW) - 1) m_cnt = m_cnt + NW'(1);
            end else begin
                m_exe = id;
            end
        end
        last_stall = stl;
        e.stall = stl; e.exe = m_exe; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Present an instruction and hold it until the pipeline accepts it.
    task automatic issue(input instr_t id, input bit u1, input bit u2, input bit fwd);
        int n = 0;
        do begin
            step(id, u1, u2, fwd, 1'b0, 1'b0, 1'b1);
            n++;
        end while (last_stall && n < 10);
        if (last_stall) chk("stall_bound", 128'(1), 128'(0));
    endtask

    task automatic idle(input bit fwd);
        step('0, 1'b0, 1'b0, fwd, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        repeat (2) step(rand_instr(), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: stall_id before each edge, exe_* and counter after it.
    initial begin
        logic s;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            s = stall_id;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_id", 128'(s), 128'(e.stall));
                chk("exe_fields", 128'({exe_valid, exe_src1, exe_src2, exe_dest, exe_val1,
                    exe_val2, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_cmd}), 128'(e.exe));
                chk("stall_cycles", 128'(stall_cycles), 128'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        instr_t a, b, x;
        // Reset held with random inputs, then first instruction one edge after release.
        repeat (3) step(rand_instr(), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        x = mk(1'b1, 1, 2, 6, 1'b1, 1'b0);
        issue(x, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("post_reset_val1", 128'(exe_val1), 128'(x.val1));
        chk("post_reset_valid", 128'(exe_valid), 128'(1));

        // Load-use with forwarding: one bubble.
        do_reset();
        issue(mk(1'b1, 0, 0, 3, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
        issue(mk(1'b1, 3, 9, 4, 1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("load_use_cnt", 128'(stall_cycles), 128'(1));

        // ALU dependence: none with forwarding, two bubbles without.
        do_reset();
        issue(mk(1'b1, 0, 0, 2, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
        issue(mk(1'b1, 7, 2, 8, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("alu_fwd_cnt", 128'(stall_cycles), 128'(0));
        do_reset();
        issue(mk(1'b1, 0, 0, 2, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        issue(mk(1'b1, 7, 2, 8, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("alu_nofwd_cnt", 128'(stall_cycles), 128'(2));

        // Unused source never stalls.
        do_reset();
        issue(mk(1'b1, 0, 0, 5, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        issue(mk(1'b1, 1, 5, 9, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("unused_src_cnt", 128'(stall_cycles), 128'(0));

        // Freeze holds, flush bubbles, freeze beats flush.
        do_reset();
        a = mk(1'b1, 1, 2, 3, 1'b1, 1'b0);
        issue(a, 1'b1, 1'b1, 1'b1);
        repeat (3) step(rand_instr(), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(rand_instr(), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("freeze_hold_val1", 128'(exe_val1), 128'(a.val1));
        b = mk(1'b1, 4, 5, 6, 1'b1, 1'b0);
        issue(b, 1'b1, 1'b1, 1'b1);
        chk("flush_bubble", 128'(exe_valid), 128'(0));
        step(rand_instr(), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("freeze_flush_val1", 128'(exe_val1), 128'(b.val1));
        chk("freeze_flush_valid", 128'(exe_valid), 128'(1));

        // Counter saturation over 20 load-use hazards.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            issue(mk(1'b1, 0, 0, 3, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
            issue(mk(1'b1, 3, 0, 7, 1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
        end
        idle(1'b1);
        chk("sat_cnt", 128'(stall_cycles), 128'(15));

        // Random traffic, including resets, freezes and flushes at arbitrary points.
        for (int i = 0; i < 500; i++) begin
            step(rand_instr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0));
        end
        idle(1'b1);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
